// File: rtl/tx_sched_arbiter.sv
// Shares one serial transmitter among NREQ requesters: round-robin grant, load/send/tx_end handshake, watchdog abort.
// Define TX_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module tx_sched_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 2047
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*DATA_W-1:0]   req_data_i,
    input  logic                     dsr_i,
    input  logic                     tx_end_i,
    output logic                     tx_load_o,
    output logic                     tx_send_o,
    output logic [DATA_W-1:0]        tx_data_o,
    output logic [NREQ-1:0]          grant_o,
    output logic [NREQ-1:0]          ack_o,
    output logic                     timeout_o,
    output logic                     busy_o,
    output logic [15:0]              frame_cnt_o
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [11:0] WCNT_LAST = 12'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_END,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                tx_load_q;
    logic                tx_send_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic [NREQ-1:0]     grant_q;
    logic [NREQ-1:0]     ack_q;
    logic                timeout_q;
    logic                busy_q;
    logic [15:0]         frame_cnt_q;
    logic [11:0]         wcnt_q;
    logic [LW-1:0]       win_d;
    logic                found_d;

`ifdef TX_ARB_FIXED_PRIO_EN
    always_comb begin
        win_d   = '0;
        found_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_d && req_i[i]) begin
                win_d   = LW'(i);
                found_d = 1'b1;
            end
        end
    end
`else
    logic [LW-1:0] last_q;
    int            idx_d;

    // Scan starts one past the previous winner and wraps.
    always_comb begin
        win_d   = '0;
        found_d = 1'b0;
        idx_d   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_d = int'(last_q) + k;
            if (idx_d >= NREQ) idx_d = idx_d - NREQ;
            if (!found_d && req_i[LW'(idx_d)]) begin
                win_d   = LW'(idx_d);
                found_d = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            tx_load_q   <= 1'b0;
            tx_send_q   <= 1'b0;
            tx_data_q   <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            wcnt_q      <= '0;
`ifndef TX_ARB_FIXED_PRIO_EN
            last_q      <= LW'(NREQ - 1);
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dsr_i && (|req_i)) begin
`ifndef TX_ARB_FIXED_PRIO_EN
                        last_q <= win_d;
`endif
                        tx_data_q <= req_data_i[int'(win_d)*DATA_W +: DATA_W];
                        grant_q   <= NREQ'(1) << win_d;
                        tx_load_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_load_q <= 1'b0;
                    tx_send_q <= 1'b1;
                    state_q   <= S_SEND;
                end
                S_SEND: begin
                    tx_send_q <= 1'b0;
                    wcnt_q    <= '0;
                    state_q   <= S_WAIT_END;
                end
                S_WAIT_END: begin
                    // A tx_end arriving on the last watchdog cycle still counts as success.
                    if (tx_end_i) begin
                        ack_q   <= grant_q;
                        state_q <= S_DONE;
                        if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
                    end else if (wcnt_q == WCNT_LAST) begin
                        ack_q     <= grant_q;
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        wcnt_q <= wcnt_q + 12'd1;
                    end
                end
                S_DONE: begin
                    ack_q     <= '0;
                    timeout_q <= 1'b0;
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_load_o   = tx_load_q;
    assign tx_send_o   = tx_send_q;
    assign tx_data_o   = tx_data_q;
    assign grant_o     = grant_q;
    assign ack_o       = ack_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = busy_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_tx_sched_arbiter.sv
// Directed bench for tx_sched_arbiter: main instance (TIMEOUT=32) plus a watchdog instance (TIMEOUT=16).
module tb_tx_sched_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        dsr = 1'b0;
    logic        tx_end = 1'b0;
    logic        tx_load, tx_send, timeout, busy;
    logic [7:0]  tx_data;
    logic [3:0]  grant, ack;
    logic [15:0] frame_cnt;

    logic [3:0]  req_w = '0;
    logic [31:0] req_data_w = 32'h4433_2211;
    logic        tx_end_w = 1'b0;
    logic        tx_load_w, tx_send_w, timeout_w, busy_w;
    logic [7:0]  tx_data_w;
    logic [3:0]  grant_w, ack_w;
    logic [15:0] frame_cnt_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tx_sched_arbiter #(.NREQ(4), .DATA_W(8), .TIMEOUT(32)) dut (
        .clock_i(clk), .reset_i(rst), .req_i(req), .req_data_i(req_data), .dsr_i(dsr),
        .tx_end_i(tx_end), .tx_load_o(tx_load), .tx_send_o(tx_send), .tx_data_o(tx_data),
        .grant_o(grant), .ack_o(ack), .timeout_o(timeout), .busy_o(busy), .frame_cnt_o(frame_cnt)
    );

    tx_sched_arbiter #(.NREQ(4), .DATA_W(8), .TIMEOUT(16)) dut_wd (
        .clock_i(clk), .reset_i(rst), .req_i(req_w), .req_data_i(req_data_w), .dsr_i(dsr),
        .tx_end_i(tx_end_w), .tx_load_o(tx_load_w), .tx_send_o(tx_send_w), .tx_data_o(tx_data_w),
        .grant_o(grant_w), .ack_o(ack_w), .timeout_o(timeout_w), .busy_o(busy_w),
        .frame_cnt_o(frame_cnt_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; req_w = '0; tx_end = 1'b0; tx_end_w = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_load(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_load && n < 60);
        if (!tx_load) chk("load_wait", {31'd0, tx_load}, 32'd1);
    endtask

    task automatic run_frame(input int dly, output logic [3:0] g);
        int n;
        wait_load(n);
        g = grant;
        @(negedge clk);
        chk("frame_send", {31'd0, tx_send}, 32'd1);
        repeat (dly) @(negedge clk);
        tx_end = 1'b1;
        @(negedge clk);
        tx_end = 1'b0;
        chk("frame_ack", {28'd0, ack}, {28'd0, g});
    endtask

    logic [3:0] g;
    logic [3:0] exp_fair [5];
    logic [3:0] exp_prio [3];
    int n;

    initial begin
`ifdef TX_ARB_FIXED_PRIO_EN
        exp_fair = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_prio = '{4'b0010, 4'b0010, 4'b0010};
`else
        exp_fair = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_prio = '{4'b0010, 4'b0100, 4'b1000};
`endif
        // Reset values
        @(negedge clk);
        chk("rst_ctl", {28'd0, tx_load, tx_send, busy, timeout}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_grant_ack", {24'd0, grant, ack}, 32'd0);
        chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);

        // Single request
        do_reset();
        req = 4'b0010; req_data[15:8] = 8'hA5; dsr = 1'b1;
        @(negedge clk);
        chk("s_load", {31'd0, tx_load}, 32'd1);
        chk("s_data", {24'd0, tx_data}, 32'hA5);
        chk("s_grant", {28'd0, grant}, 32'b0010);
        @(negedge clk);
        chk("s_send", {30'd0, tx_send, tx_load}, 32'b10);
        req_data[15:8] = 8'hFF;
        repeat (20) @(negedge clk);
        chk("s_grant_hold", {28'd0, grant}, 32'b0010);
        chk("s_data_hold", {24'd0, tx_data}, 32'hA5);
        chk("s_busy", {31'd0, busy}, 32'd1);
        tx_end = 1'b1;
        @(negedge clk);
        tx_end = 1'b0;
        chk("s_ack", {28'd0, ack}, 32'b0010);
        chk("s_to", {31'd0, timeout}, 32'd0);
        chk("s_cnt", {16'd0, frame_cnt}, 32'd1);
        req = '0;
        @(negedge clk);
        chk("s_idle", {23'd0, ack, grant, busy}, 32'd0);

        // tx_end outside WAIT_END is ignored
        tx_end = 1'b1;
        @(negedge clk);
        tx_end = 1'b0;
        @(negedge clk);
        chk("stray_end", {15'd0, busy, frame_cnt}, 32'd1);

        // Fairness
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_frame(5, g);
            chk($sformatf("fair_%0d", i), {28'd0, g}, {28'd0, exp_fair[i]});
        end
        chk("fair_cnt", {16'd0, frame_cnt}, 32'd5);

        // dsr gating
        do_reset();
        dsr = 1'b0; req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("dsr_hold", {30'd0, busy, tx_load}, 32'd0);
        end
        dsr = 1'b1;
        wait_load(n);
        chk("dsr_lat", n, 32'd1);

        // Watchdog abort and tx_end on the final watchdog cycle
        do_reset();
        req_w = 4'b0100;
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_load_w && n < 60);
        @(negedge clk);
        chk("wd_send", {31'd0, tx_send_w}, 32'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (ack_w == 4'b0000 && n < 40);
        chk("wd_lat", n, 32'd17);
        chk("wd_ack", {28'd0, ack_w}, 32'b0100);
        chk("wd_to", {31'd0, timeout_w}, 32'd1);
        chk("wd_cnt", {16'd0, frame_cnt_w}, 32'd0);
        req_w = '0;
        @(negedge clk);
        chk("wd_clear", {27'd0, ack_w, timeout_w}, 32'd0);
        req_w = 4'b0100;
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_load_w && n < 60);
        @(negedge clk);
        chk("wd2_send", {31'd0, tx_send_w}, 32'd1);
        repeat (15) @(negedge clk);
        chk("wd2_noack", {28'd0, ack_w}, 32'd0);
        @(negedge clk);
        tx_end_w = 1'b1;
        @(negedge clk);
        tx_end_w = 1'b0;
        chk("wd2_ack", {28'd0, ack_w}, 32'b0100);
        chk("wd2_to", {31'd0, timeout_w}, 32'd0);
        chk("wd2_cnt", {16'd0, frame_cnt_w}, 32'd1);
        req_w = '0;

        // Reset mid-frame
        do_reset();
        req = 4'b0100;
        wait_load(n);
        chk("mr_grant", {28'd0, grant}, 32'b0100);
        repeat (4) @(negedge clk);
        chk("mr_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_ctl", {28'd0, tx_load, tx_send, busy, timeout}, 32'd0);
        chk("mr_out", {16'd0, tx_data, grant, ack}, 32'd0);
        @(negedge clk);
        chk("mr_noack", {28'd0, ack}, 32'd0);
        rst = 1'b0; req = 4'b1111;
        wait_load(n);
        chk("mr_regrant", {28'd0, grant}, 32'b0001);

        // Three frames with req = 1110 held
        do_reset();
        req = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            run_frame(3, g);
            chk($sformatf("prio_%0d", i), {28'd0, g}, {28'd0, exp_prio[i]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
